// File: rtl/aes_add_round_key_stage_if.sv
// Valid/ready stream carrying one AES state plus its round index.
// The producer side uses the master modport and the consumer side uses the slave modport.
interface aes_add_round_key_stage_if #(
    parameter int DATA_W  = 128,
    parameter int ROUND_W = 4
);
    logic               valid;
    logic               ready;
    logic [DATA_W-1:0]  data;
    logic [ROUND_W-1:0] round;

    modport master (
        output valid,
        output data,
        output round,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  round,
        output ready
    );
endinterface

// File: rtl/aes_add_round_key_stage.sv
// AES-128 AddRoundKey stage with a serially loaded round-key store.
//
// Expanded key words w[0..4*(NR+1)-1] are written one per key_wr_en pulse.
// key_load_start rewinds the write pointer. Each accepted state is XORed with
// round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}, where r = in_round. The result
// is held in a valid/ready output register.
//
// A state whose round index is out of range passes through unmodified. It also
// sets the sticky round_err flag.
//
// Optional feature: define AES_ARK_SKID_EN to add a one-entry skid register.
// With it, in_ready is a flop and does not depend combinationally on out_ready.
module aes_add_round_key_stage #(
    parameter int NR = 10
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             key_load_start,
    input  logic                             key_wr_en,
    input  logic [31:0]                      key_wr_data,
    output logic                             keys_valid,
    aes_add_round_key_stage_if.slave         in_if,
    aes_add_round_key_stage_if.master        out_if,
    output logic                             round_err
);

    localparam int              KEY_WORDS  = 4 * (NR + 1);
    localparam int              WP_W       = $clog2(KEY_WORDS + 1);
    localparam logic [WP_W-1:0] WP_FULL    = WP_W'(KEY_WORDS);
    localparam logic [3:0]      LAST_ROUND = 4'(NR);

    // ------------------------------------------------------------------
    // Key store and fill tracking
    // ------------------------------------------------------------------
    logic [31:0]     store_q [KEY_WORDS];
    logic [WP_W-1:0] wp_q, wp_d;
    logic [WP_W-1:0] wp_base;
    logic            keys_valid_q, keys_valid_d;
    logic            key_we;

    // Write pointer and fill flag. A load-start pulse rewinds the pointer before any same-cycle write.
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        wp_base      = key_load_start ? '0 : wp_q;
        wp_d         = wp_base;
        keys_valid_d = key_load_start ? 1'b0 : keys_valid_q;
        key_we       = 1'b0;
        if (key_wr_en && (wp_base < WP_FULL)) begin
            key_we = 1'b1;
            wp_d   = wp_base + WP_W'(1);
            if (wp_base == (WP_FULL - WP_W'(1))) begin
                keys_valid_d = 1'b1;
            end
        end
    end

    // Key word storage. A full store ignores further writes until the next load-start.
    // NOTE: the key store has no reset; after any reset it is reloaded before keys_valid allows use.
    always_ff @(posedge clk) begin
        if (key_we) begin
            store_q[wp_base] <= key_wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Round-key selection and XOR
    // ------------------------------------------------------------------
    logic [WP_W-1:0] rk_base;
    logic [127:0]    round_key;
    logic [127:0]    keyed_data;
    logic            round_bad;
    logic            accept;

    assign rk_base    = WP_W'({in_if.round, 2'b00});
    assign round_bad  = (in_if.round > LAST_ROUND);
    assign keyed_data = in_if.data ^ round_key;
    assign accept     = in_if.valid & in_if.ready;

    // Round key selection. An out-of-range round contributes an all-zero key.
    always_comb begin
        round_key = '0;
        if (!round_bad) begin
            round_key = {store_q[rk_base],
                         store_q[rk_base + WP_W'(1)],
                         store_q[rk_base + WP_W'(2)],
                         store_q[rk_base + WP_W'(3)]};
        end
    end

    // ------------------------------------------------------------------
    // Output register and sticky error
    // ------------------------------------------------------------------
    logic         out_valid_q, out_valid_d;
    logic [127:0] out_data_q,  out_data_d;
    logic [3:0]   out_round_q, out_round_d;
    logic         round_err_q, round_err_d;

    // Sticky error: set by any accepted state whose round index is out of range.
    always_comb begin
        round_err_d = round_err_q | (accept & round_bad);
    end

`ifdef AES_ARK_SKID_EN
    // ------------------------------------------------------------------
    // Skid variant: registered in_ready, one spare entry behind the output
    // ------------------------------------------------------------------
    logic         skid_full_q,  skid_full_d;
    logic [127:0] skid_data_q,  skid_data_d;
    logic [3:0]   skid_round_q, skid_round_d;
    logic         in_ready_q,   in_ready_d;
    logic         out_free;

    assign in_if.ready = in_ready_q;
    assign out_free    = ~out_valid_q | out_if.ready;

    // Output and skid next state. The skid entry always drains before new input, which keeps order.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_round_d  = out_round_q;
        skid_full_d  = skid_full_q;
        skid_data_d  = skid_data_q;
        skid_round_d = skid_round_q;
        if (out_free) begin
            if (skid_full_q) begin
                out_valid_d = 1'b1;
                out_data_d  = skid_data_q;
                out_round_d = skid_round_q;
                if (accept) begin
                    skid_data_d  = keyed_data;
                    skid_round_d = in_if.round;
                end else begin
                    skid_full_d = 1'b0;
                end
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_data_d  = keyed_data;
                out_round_d = in_if.round;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_full_d  = 1'b1;
            skid_data_d  = keyed_data;
            skid_round_d = in_if.round;
        end
        in_ready_d = keys_valid_d & ~skid_full_d;
    end

    // Skid register and registered ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_full_q  <= 1'b0;
            skid_data_q  <= '0;
            skid_round_q <= '0;
            in_ready_q   <= 1'b0;
        end else begin
            skid_full_q  <= skid_full_d;
            skid_data_q  <= skid_data_d;
            skid_round_q <= skid_round_d;
            in_ready_q   <= in_ready_d;
        end
    end
`else
    // ------------------------------------------------------------------
    // Plain variant: in_ready looks through to out_ready combinationally
    // ------------------------------------------------------------------
    assign in_if.ready = keys_valid_q & (~out_valid_q | out_if.ready);

    // Output next state: load on accept, otherwise release once downstream takes the held state.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_round_d = out_round_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = keyed_data;
            out_round_d = in_if.round;
        end else if (out_if.ready) begin
            out_valid_d = 1'b0;
        end
    end
`endif

    // State registers for key fill, output stage and error flag.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q         <= '0;
            keys_valid_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_round_q  <= '0;
            round_err_q  <= 1'b0;
        end else begin
            wp_q         <= wp_d;
            keys_valid_q <= keys_valid_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_round_q  <= out_round_d;
            round_err_q  <= round_err_d;
        end
    end

    assign keys_valid   = keys_valid_q;
    assign round_err    = round_err_q;
    assign out_if.valid = out_valid_q;
    assign out_if.data  = out_data_q;
    assign out_if.round = out_round_q;

endmodule

// File: tb/tb_aes_add_round_key_stage.sv
// Self-checking bench for aes_add_round_key_stage.
//
// A reference model holds the key words and a queue of expected outputs. The
// compare process checks every output transfer against that queue and checks
// that a stalled output holds still. FIPS-197 literals pin the model.
module tb_aes_add_round_key_stage;

    localparam int NR        = 10;
    localparam int KEY_WORDS = 4 * (NR + 1);
`ifdef AES_ARK_SKID_EN
    localparam int STALL_ACCEPTS = 2;
`else
    localparam int STALL_ACCEPTS = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        key_load_start;
    logic        key_wr_en;
    logic [31:0] key_wr_data;
    logic        keys_valid;
    logic        round_err;

    aes_add_round_key_stage_if in_bus ();
    aes_add_round_key_stage_if out_bus ();

    aes_add_round_key_stage #(.NR(NR)) dut (
        .clk            (clk),
        .rst            (rst),
        .key_load_start (key_load_start),
        .key_wr_en      (key_wr_en),
        .key_wr_data    (key_wr_data),
        .keys_valid     (keys_valid),
        .in_if          (in_bus),
        .out_if         (out_bus),
        .round_err      (round_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [127:0] data;
        logic [3:0]   round;
    } xfer_t;

    logic [31:0]  model_key [KEY_WORDS];
    int           model_wp = 0;
    xfer_t        exp_q[$];
    int           accept_cnt = 0;
    int           out_cnt    = 0;
    logic [127:0] last_data  = '0;
    logic [3:0]   last_round = '0;
    logic [31:0]  key_a [KEY_WORDS];
    logic [31:0]  key_b [KEY_WORDS];

    task automatic check_vec(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: state XOR the four key words of its round, or unchanged if the round is out of range.
    function automatic logic [127:0] model_out(input logic [127:0] d, input logic [3:0] r);
        int ri;
        ri = int'(r);
        if (ri > NR) return d;
        return d ^ {model_key[4*ri], model_key[4*ri+1], model_key[4*ri+2], model_key[4*ri+3]};
    endfunction

    task automatic pulse_load();
        key_load_start = 1'b1;
        model_wp       = 0;
        @(negedge clk);
        key_load_start = 1'b0;
    endtask

    task automatic write_word(input logic [31:0] w);
        key_wr_en   = 1'b1;
        key_wr_data = w;
        if (model_wp < KEY_WORDS) begin
            model_key[model_wp] = w;
            model_wp++;
        end
        @(negedge clk);
        key_wr_en = 1'b0;
    endtask

    // Writes all key words of set A or B and checks the fill flag around the final write.
    task automatic write_set(input bit use_b);
        for (int i = 0; i < KEY_WORDS; i++) begin
            write_word(use_b ? key_b[i] : key_a[i]);
            if (i >= KEY_WORDS - 2) begin
                check_bit("keys_valid_fill", keys_valid, model_wp == KEY_WORDS);
            end
            if (i == KEY_WORDS - 2) begin
                check_bit("in_ready_unfilled", in_bus.ready, 1'b0);
            end
        end
    endtask

    // Offers one state. On acceptance, queues the expected result and returns at the next falling edge.
    task automatic send(input logic [127:0] d, input logic [3:0] r);
        in_bus.valid = 1'b1;
        in_bus.data  = d;
        in_bus.round = r;
        for (int k = 0; k < 100; k++) begin
            #1;
            if (in_bus.ready === 1'b1) begin
                exp_q.push_back('{data: model_out(d, r), round: r});
                accept_cnt++;
                @(negedge clk);
                in_bus.valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        check_bit("send_timeout", 1'b0, 1'b1);
        in_bus.valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && out_bus.valid == 1'b0) return;
        end
        check_bit("drain_timeout", 1'b0, 1'b1);
    endtask

    // Compare process: check each transfer against the model and check that a stalled output holds still.
    logic         hold = 1'b0;
    logic [127:0] hold_data;
    logic [3:0]   hold_round;
    always @(negedge clk) begin
        #2;
        if (rst === 1'b1) begin
            exp_q.delete();
            hold = 1'b0;
        end else begin
            if (hold) begin
                check_bit("hold_valid", out_bus.valid, 1'b1);
                check_vec("hold_data", out_bus.data, hold_data);
                check_vec("hold_round", 128'(out_bus.round), 128'(hold_round));
            end
            hold = 1'b0;
            if (out_bus.valid === 1'b1) begin
                if (out_bus.ready === 1'b1) begin
                    check_bit("out_expected", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) begin
                        xfer_t e;
                        e = exp_q.pop_front();
                        check_vec("out_data", out_bus.data, e.data);
                        check_vec("out_round", 128'(out_bus.round), 128'(e.round));
                    end
                    last_data  = out_bus.data;
                    last_round = out_bus.round;
                    out_cnt++;
                end else begin
                    hold       = 1'b1;
                    hold_data  = out_bus.data;
                    hold_round = out_bus.round;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int c0;
        int o0;
        for (int i = 0; i < KEY_WORDS; i++) begin
            key_a[i] = 32'h9e3779b9 * (i + 1);
        end
        key_a[0]  = 32'h00010203; key_a[1]  = 32'h04050607;
        key_a[2]  = 32'h08090a0b; key_a[3]  = 32'h0c0d0e0f;
        key_a[40] = 32'h13111d7f; key_a[41] = 32'he3944a17;
        key_a[42] = 32'hf307a78b; key_a[43] = 32'h4d2b30c5;
        for (int i = 0; i < KEY_WORDS; i++) begin
            key_b[i] = ~key_a[i];
        end

        rst            = 1'b1;
        key_load_start = 1'b0;
        key_wr_en      = 1'b0;
        key_wr_data    = '0;
        in_bus.valid   = 1'b0;
        in_bus.data    = '0;
        in_bus.round   = '0;
        out_bus.ready  = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check_bit("rst_keys_valid", keys_valid, 1'b0);
        check_bit("rst_in_ready", in_bus.ready, 1'b0);
        check_bit("rst_out_valid", out_bus.valid, 1'b0);
        check_vec("rst_out_data", out_bus.data, 128'h0);
        check_vec("rst_out_round", 128'(out_bus.round), 128'h0);
        check_bit("rst_round_err", round_err, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Load key set A, then run the round 0 and round 10 vectors
        pulse_load();
        write_set(1'b0);
        check_bit("keys_valid_loaded", keys_valid, 1'b1);
        send(128'h00112233445566778899aabbccddeeff, 4'd0);
        drain();
        check_vec("r0_literal", last_data, 128'h00102030405060708090a0b0c0d0e0f0);
        check_vec("r0_round", 128'(last_round), 128'h0);
        send(128'hbd6e7c3df2b5779e0b61216e8b10b689, 4'd10);
        drain();
        check_vec("r10_literal_a", last_data, 128'hae7f614211213d89f86686e5c63b864c);
        send(128'h7ad5fda789ef4e272bca100b3d9ff59f, 4'd10);
        drain();
        check_vec("r10_literal_fips", last_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        check_vec("r10_round", 128'(last_round), 128'd10);

        // Throughput: one state per cycle with out_ready held high
        t0 = int'($time);
        for (int r = 1; r <= 9; r++) begin
            send({4{32'h1f2e3d4c ^ 32'(r * 32'h01010101)}}, 4'(r));
        end
        check_int("throughput_cycles", (int'($time) - t0) / 10, 9);
        drain();

        // Backpressure: four back-to-back states while out_ready is low for three cycles
        c0 = accept_cnt;
        o0 = out_cnt;
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    send({32'hcafe0000 + 32'(k), 32'h0, 32'hffffffff, 32'(k * 7)}, 4'(k + 2));
                end
            end
            begin
                int s0;
                out_bus.ready = 1'b0;
                s0 = accept_cnt;
                repeat (2) @(negedge clk);
                #1;
                check_bit("stall_in_ready", in_bus.ready, 1'b0);
                @(negedge clk);
                check_int("stall_accepts", accept_cnt - s0, STALL_ACCEPTS);
                out_bus.ready = 1'b1;
            end
        join
        drain();
        check_int("bp_accepted", accept_cnt - c0, 4);
        check_int("bp_delivered", out_cnt - o0, 4);

        // Bad round passes data unchanged and sets the sticky error
        check_bit("round_err_clear", round_err, 1'b0);
        send(128'h0123456789abcdef0123456789abcdef, 4'd11);
        drain();
        check_vec("bad_round_data", last_data, 128'h0123456789abcdef0123456789abcdef);
        check_vec("bad_round_round", 128'(last_round), 128'd11);
        check_bit("round_err_set", round_err, 1'b1);

        // Reload while an output is held
        out_bus.ready = 1'b0;
        send(128'h55aa55aa00ff00ff1234567890abcdef, 4'd3);
        check_bit("reload_pre_valid", out_bus.valid, 1'b1);
        pulse_load();
        check_bit("reload_keys_valid", keys_valid, 1'b0);
        check_bit("reload_in_ready", in_bus.ready, 1'b0);
        write_set(1'b1);
        write_word(32'hdeadbeef);
        check_bit("keys_valid_after_45", keys_valid, 1'b1);
        check_bit("reload_still_held", out_bus.valid, 1'b1);
        out_bus.ready = 1'b1;
        drain();
        send(128'h00112233445566778899aabbccddeeff, 4'd0);
        drain();
        check_vec("reload_r0_literal", last_data, 128'hffefdfcfbfaf9f8f7f6f5f4f3f2f1f0f);
        check_bit("round_err_sticky", round_err, 1'b1);

        // Reset while an output is held
        out_bus.ready = 1'b0;
        send(128'h0f0e0d0c0b0a09080706050403020100, 4'd1);
        check_bit("rst_mid_pre_valid", out_bus.valid, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_bit("rst_mid_out_valid", out_bus.valid, 1'b0);
        check_bit("rst_mid_keys_valid", keys_valid, 1'b0);
        check_bit("rst_mid_in_ready", in_bus.ready, 1'b0);
        check_bit("rst_mid_round_err", round_err, 1'b0);
        rst           = 1'b0;
        model_wp      = 0;
        out_bus.ready = 1'b1;
        repeat (2) @(negedge clk);
        check_bit("post_rst_out_valid", out_bus.valid, 1'b0);
        check_int("post_rst_queue", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
